// File: rtl/zpulse_stats.sv
// zpulse_stats: gain-scaled photon pulse samples, saturating accumulator and per-frame max/min.
// Define ZPULSE_STATS_PEAKHOLD_EN to keep running max/min across frames until iClear or en=0.
module zpulse_stats #(
  parameter int POINTS = 600,
  parameter int IDX_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             iPause,
  input  logic             iClear,
  input  logic             iPulse_Valid,
  input  logic [31:0]      iPulse_Count,
  input  logic [7:0]       iGain_Divider,
  output logic             oData_Update,
  output logic [31:0]      oPulse_Counter,
  output logic [31:0]      oPulseCounter_Accumulated,
  output logic [15:0]      oMaxPulseCounter,
  output logic [15:0]      oMinPulseCounter,
  output logic [IDX_W-1:0] oPoint_Index,
  output logic             oFrame_Done
);

  typedef enum logic [1:0] {DISABLED, CLEAR, PAUSE, RUN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POINTS - 1);

  state_t      stateReg;
  state_t      stateNext;
  logic        accept;
  logic [2:0]  shiftAmt;
  logic [31:0] scaled;
  logic [31:0] s1Reg;
  logic        v1Reg;
  logic [15:0] runMaxReg;
  logic [15:0] runMinReg;
  logic [15:0] sat16;
  logic [15:0] maxNew;
  logic [15:0] minNew;
  logic [32:0] accSum;
  logic        lastPoint;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateReg <= DISABLED;
    else        stateReg <= stateNext;
  end

  // stateNext is the mode applied to this cycle's inputs; a sample is only taken
  // once the registered state has left DISABLED, i.e. one cycle after en rises.
  always_comb begin
    stateNext = RUN;
    accept    = 1'b0;
    if (!en)         stateNext = DISABLED;
    else if (iClear) stateNext = CLEAR;
    else if (iPause) stateNext = PAUSE;
    if (stateNext == RUN && stateReg != DISABLED) accept = iPulse_Valid;
  end

  assign shiftAmt  = (iGain_Divider > 8'd7) ? 3'd7 : iGain_Divider[2:0];
  assign scaled    = iPulse_Count >> shiftAmt;
  assign sat16     = (s1Reg > 32'h0000_FFFF) ? 16'hFFFF : s1Reg[15:0];
  assign maxNew    = (sat16 > runMaxReg) ? sat16 : runMaxReg;
  assign minNew    = (sat16 < runMinReg) ? sat16 : runMinReg;
  assign accSum    = {1'b0, oPulseCounter_Accumulated} + {1'b0, s1Reg};
  assign lastPoint = (oPoint_Index == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Reg                     <= '0;
      v1Reg                     <= 1'b0;
      runMaxReg                 <= 16'h0000;
      runMinReg                 <= 16'hFFFF;
      oData_Update              <= 1'b0;
      oPulse_Counter            <= '0;
      oPulseCounter_Accumulated <= '0;
      oMaxPulseCounter          <= '0;
      oMinPulseCounter          <= '0;
      oPoint_Index              <= '0;
      oFrame_Done               <= 1'b0;
    end else if (stateNext == DISABLED) begin
      s1Reg                     <= '0;
      v1Reg                     <= 1'b0;
      runMaxReg                 <= 16'h0000;
      runMinReg                 <= 16'hFFFF;
      oData_Update              <= 1'b0;
      oPulse_Counter            <= '0;
      oPulseCounter_Accumulated <= '0;
      oMaxPulseCounter          <= '0;
      oMinPulseCounter          <= '0;
      oPoint_Index              <= '0;
      oFrame_Done               <= 1'b0;
    end else begin
      oData_Update <= 1'b0;
      oFrame_Done  <= 1'b0;
      v1Reg        <= accept;
      if (accept) s1Reg <= scaled;
      if (stateNext == CLEAR) begin
        // Clear also discards whatever sits in stage 1 (v1Reg <= accept is 0 here).
        oPulseCounter_Accumulated <= '0;
        oPoint_Index              <= '0;
        runMaxReg                 <= 16'h0000;
        runMinReg                 <= 16'hFFFF;
        oMaxPulseCounter          <= '0;
        oMinPulseCounter          <= '0;
      end else if (v1Reg) begin
        oData_Update              <= 1'b1;
        oPulse_Counter            <= s1Reg;
        oPulseCounter_Accumulated <= accSum[32] ? 32'hFFFF_FFFF : accSum[31:0];
        if (lastPoint) begin
          oMaxPulseCounter <= maxNew;
          oMinPulseCounter <= minNew;
          oFrame_Done      <= 1'b1;
          oPoint_Index     <= '0;
`ifdef ZPULSE_STATS_PEAKHOLD_EN
          runMaxReg        <= maxNew;
          runMinReg        <= minNew;
`else
          runMaxReg        <= 16'h0000;
          runMinReg        <= 16'hFFFF;
`endif
        end else begin
          runMaxReg    <= maxNew;
          runMinReg    <= minNew;
          oPoint_Index <= oPoint_Index + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_zpulse_stats.sv
// tb_zpulse_stats: table-driven gain/latency vectors, directed frame/pause/clear/reset
// sequences and randomized traffic, all checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_zpulse_stats;

  localparam int POINTS = 600;
  localparam int IDX_W  = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             iPause = 1'b0;
  logic             iClear = 1'b0;
  logic             iPulse_Valid = 1'b0;
  logic [31:0]      iPulse_Count = '0;
  logic [7:0]       iGain_Divider = '0;
  logic             oData_Update;
  logic [31:0]      oPulse_Counter;
  logic [31:0]      oPulseCounter_Accumulated;
  logic [15:0]      oMaxPulseCounter;
  logic [15:0]      oMinPulseCounter;
  logic [IDX_W-1:0] oPoint_Index;
  logic             oFrame_Done;

  zpulse_stats #(.POINTS(POINTS), .IDX_W(IDX_W)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .en                        (en),
    .iPause                    (iPause),
    .iClear                    (iClear),
    .iPulse_Valid              (iPulse_Valid),
    .iPulse_Count              (iPulse_Count),
    .iGain_Divider             (iGain_Divider),
    .oData_Update              (oData_Update),
    .oPulse_Counter            (oPulse_Counter),
    .oPulseCounter_Accumulated (oPulseCounter_Accumulated),
    .oMaxPulseCounter          (oMaxPulseCounter),
    .oMinPulseCounter          (oMinPulseCounter),
    .oPoint_Index              (oPoint_Index),
    .oFrame_Done               (oFrame_Done)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: accepted samples wait in a queue until due; a frame's
  // statistics are recomputed from the list of its saturated values.
  typedef struct {
    int unsigned due;
    logic [31:0] val;
  } pend_t;

  pend_t       pq[$];
  logic [15:0] fv[$];
  int unsigned cyc = 0;
  bit          enPrev = 0;
  logic [31:0] mPulse = '0;
  logic [31:0] mAcc = '0;
  logic [15:0] mMax = '0;
  logic [15:0] mMin = '0;
  int          mIdx = 0;
  logic        mUpd = 0;
  logic        mDone = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pq.delete(); fv.delete();
      enPrev = 0; mPulse = '0; mAcc = '0; mMax = '0; mMin = '0;
      mIdx = 0; mUpd = 0; mDone = 0;
    end else begin
      cyc++;
      mUpd = 0;
      mDone = 0;
      if (!en || iClear) begin
        pq.delete(); fv.delete();
        mAcc = '0; mIdx = 0; mMax = '0; mMin = '0;
        if (!en) mPulse = '0;
      end else begin
        if (pq.size() > 0 && pq[0].due == cyc) begin
          pend_t e;
          longint unsigned s;
          logic [15:0] v16, mx, mn;
          e = pq.pop_front();
          mPulse = e.val;
          mUpd = 1;
          s = longint'(mAcc) + longint'(e.val);
          mAcc = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
          v16 = (e.val > 32'd65535) ? 16'hFFFF : e.val[15:0];
          fv.push_back(v16);
          if (mIdx == POINTS - 1) begin
            mx = 16'h0000; mn = 16'hFFFF;
            foreach (fv[i]) begin
              if (fv[i] > mx) mx = fv[i];
              if (fv[i] < mn) mn = fv[i];
            end
            mMax = mx; mMin = mn; mDone = 1; mIdx = 0;
`ifndef ZPULSE_STATS_PEAKHOLD_EN
            fv.delete();
`endif
          end else begin
            mIdx++;
          end
        end
        if (enPrev && !iPause && iPulse_Valid) begin
          int sh;
          sh = (iGain_Divider > 7) ? 7 : int'(iGain_Divider);
          pq.push_back('{cyc + 1, iPulse_Count >> sh});
        end
      end
      enPrev = en;
    end
  end

  bit modelChk = 0;
  int doneCnt = 0;
  int updCnt = 0;

  always @(negedge clk) begin
    if (oFrame_Done === 1'b1) doneCnt++;
    if (oData_Update === 1'b1) updCnt++;
    if (modelChk && rst_n) begin
      chk("model_update", 32'(oData_Update), 32'(mUpd));
      chk("model_done", 32'(oFrame_Done), 32'(mDone));
      chk("model_pulse", oPulse_Counter, mPulse);
      chk("model_acc", oPulseCounter_Accumulated, mAcc);
      chk("model_index", 32'(oPoint_Index), 32'(mIdx));
      chk("model_max", 32'(oMaxPulseCounter), 32'(mMax));
      chk("model_min", 32'(oMinPulseCounter), 32'(mMin));
    end
  end

  task automatic doClear();
    iClear = 1'b1;
    @(negedge clk);
    iClear = 1'b0;
    @(negedge clk);
  endtask

  task automatic streamVals(input logic [31:0] vals[$], input bit drain);
    foreach (vals[i]) begin
      iPulse_Valid = 1'b1;
      iPulse_Count = vals[i];
      @(negedge clk);
    end
    iPulse_Valid = 1'b0;
    if (drain) repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] cnt;
    logic [7:0]  gain;
    logic [31:0] exp;
  } gain_vec_t;

  gain_vec_t   gv[8];
  logic [31:0] q[$];
  int          savedIdx;

  initial begin
    gv[0] = '{32'd1000,      8'd2,   32'd250};
    gv[1] = '{32'h0000_8000, 8'd200, 32'd256};
    gv[2] = '{32'h0000_8000, 8'd7,   32'd256};
    gv[3] = '{32'h0000_8000, 8'd8,   32'd256};
    gv[4] = '{32'd255,       8'd0,   32'd255};
    gv[5] = '{32'hFFFF_FFFF, 8'd3,   32'h1FFF_FFFF};
    gv[6] = '{32'd70000,     8'd0,   32'd70000};
    gv[7] = '{32'd7,         8'd1,   32'd3};

    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_update", 32'(oData_Update), 32'd0);
    chk("reset_index", 32'(oPoint_Index), 32'd0);
    chk("reset_acc", oPulseCounter_Accumulated, 32'd0);
    chk("reset_min", 32'(oMinPulseCounter), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    modelChk = 1;

    // Gain table with exact two-cycle latency
    for (int i = 0; i < 8; i++) begin
      doClear();
      iGain_Divider = gv[i].gain;
      iPulse_Count  = gv[i].cnt;
      iPulse_Valid  = 1'b1;
      @(negedge clk);
      iPulse_Valid = 1'b0;
      chk("lat_n1_update", 32'(oData_Update), 32'd0);
      @(negedge clk);
      chk("lat_n2_update", 32'(oData_Update), 32'd1);
      chk("gain_value", oPulse_Counter, gv[i].exp);
      chk("gain_acc", oPulseCounter_Accumulated, gv[i].exp);
      @(negedge clk);
      chk("lat_n3_update", 32'(oData_Update), 32'd0);
    end

    // Full frame with planted extremes
    doClear();
    iGain_Divider = 8'd0;
    q.delete();
    for (int i = 0; i < POINTS; i++) q.push_back((i == 300) ? 32'd7000 : (i == 450) ? 32'd1 : 32'(i + 5));
    doneCnt = 0;
    streamVals(q, 1);
    chk("frame1_done_count", 32'(doneCnt), 32'd1);
    chk("frame1_max", 32'(oMaxPulseCounter), 32'd7000);
    chk("frame1_min", 32'(oMinPulseCounter), 32'd1);
    chk("frame1_index", 32'(oPoint_Index), 32'd0);
    q.delete();
    for (int i = 0; i < POINTS; i++) q.push_back(32'd50);
    doneCnt = 0;
    streamVals(q, 1);
    chk("frame2_done_count", 32'(doneCnt), 32'd1);
`ifdef ZPULSE_STATS_PEAKHOLD_EN
    chk("frame2_max", 32'(oMaxPulseCounter), 32'd7000);
    chk("frame2_min", 32'(oMinPulseCounter), 32'd1);
`else
    chk("frame2_max", 32'(oMaxPulseCounter), 32'd50);
    chk("frame2_min", 32'(oMinPulseCounter), 32'd50);
`endif

    // Accumulator and statistic saturation
    doClear();
    q = '{32'hFFFF_0000, 32'h0002_0000};
    streamVals(q, 1);
    chk("acc_saturate", oPulseCounter_Accumulated, 32'hFFFF_FFFF);
    q = '{32'd5};
    streamVals(q, 1);
    chk("acc_no_wrap", oPulseCounter_Accumulated, 32'hFFFF_FFFF);
    doClear();
    q.delete();
    for (int i = 0; i < POINTS - 1; i++) q.push_back(32'd10);
    q.push_back(32'd70000);
    streamVals(q, 1);
    chk("stat_sat_max", 32'(oMaxPulseCounter), 32'h0000_FFFF);
    chk("stat_sat_min", 32'(oMinPulseCounter), 32'd10);

    // Pause drops strobes and holds the index
    doClear();
    q.delete();
    for (int i = 0; i < 10; i++) q.push_back(32'd3);
    streamVals(q, 1);
    savedIdx = int'(oPoint_Index);
    iPause = 1'b1;
    updCnt = 0;
    for (int i = 0; i < 20; i++) q[i % 10] = 32'd3;
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(32'(i + 1));
    streamVals(q, 1);
    chk("pause_no_update", 32'(updCnt), 32'd0);
    chk("pause_index_held", 32'(oPoint_Index), 32'd10);
    iPause = 1'b0;
    @(negedge clk);
    q = '{32'd4};
    streamVals(q, 1);
    chk("resume_index", 32'(oPoint_Index), 32'(savedIdx + 1));

    // Clear coincident with a sample: clear wins
    iClear = 1'b1;
    iPulse_Valid = 1'b1;
    iPulse_Count = 32'd99;
    @(negedge clk);
    iClear = 1'b0;
    iPulse_Valid = 1'b0;
    updCnt = 0;
    repeat (3) @(negedge clk);
    chk("clear_no_update", 32'(updCnt), 32'd0);
    chk("clear_acc", oPulseCounter_Accumulated, 32'd0);
    chk("clear_index", 32'(oPoint_Index), 32'd0);

    // Asynchronous reset in the middle of a frame
    q.delete();
    for (int i = 0; i < 300; i++) q.push_back(32'd20);
    streamVals(q, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_update", 32'(oData_Update), 32'd0);
    chk("arst_pulse", oPulse_Counter, 32'd0);
    chk("arst_acc", oPulseCounter_Accumulated, 32'd0);
    chk("arst_index", 32'(oPoint_Index), 32'd0);
    chk("arst_max", 32'(oMaxPulseCounter), 32'd0);
    chk("arst_min", 32'(oMinPulseCounter), 32'd0);
    chk("arst_done", 32'(oFrame_Done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // en low for one cycle mid-frame, then a full 600-point frame
    q.delete();
    for (int i = 0; i < 300; i++) q.push_back(32'd9);
    streamVals(q, 1);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    chk("en_low_index", 32'(oPoint_Index), 32'd0);
    chk("en_low_acc", oPulseCounter_Accumulated, 32'd0);
    chk("en_low_pulse", oPulse_Counter, 32'd0);
    @(negedge clk);
    doneCnt = 0;
    q.delete();
    for (int i = 0; i < POINTS - 1; i++) q.push_back(32'((i % 37) + 1));
    streamVals(q, 1);
    chk("en_frame_599_no_done", 32'(doneCnt), 32'd0);
    q = '{32'd2};
    streamVals(q, 1);
    chk("en_frame_600_done", 32'(doneCnt), 32'd1);
    chk("en_frame_max", 32'(oMaxPulseCounter), 32'd37);
    chk("en_frame_min", 32'(oMinPulseCounter), 32'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 8000; c++) begin
      int r;
      iPulse_Valid = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 3));
      case (r)
        0:       iPulse_Count = $urandom_range(0, 300);
        1:       iPulse_Count = $urandom;
        2:       iPulse_Count = $urandom_range(60000, 80000);
        default: iPulse_Count = {16'hFFFF, 16'($urandom)};
      endcase
      iGain_Divider = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8));
      iClear = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 99) == 0) iPause = ~iPause;
      en = ($urandom_range(0, 1999) != 0);
      @(negedge clk);
    end
    iPulse_Valid = 1'b0;
    iClear = 1'b0;
    iPause = 1'b0;
    en = 1'b1;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
